// File: rtl/rom_pkg.sv
// Shared definitions for the program-ROM read path: geometry defaults and the
// arbiter state encoding used by rom_arbiter.
package rom_pkg;

  localparam int ROM_AW    = 13;
  localparam int ROM_DW    = 8;
  localparam int ROM_DEPTH = 2 ** ROM_AW;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request at or above ptr_i,
// wrapping modulo N. Returns a one-hot grant, its index and an any flag.
module rr_pick #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         grant_o,
  output logic [$clog2(N)-1:0] idx_o,
  output logic                 any_o
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] cand;

  // NOTE: every signal driven here gets a default at the top of the block, so no
  // path through the loop can leave one unassigned and infer a latch.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    cand    = '0;
    // Walk from the farthest offset down to ptr itself so the nearest request wins.
    for (int k = N - 1; k >= 0; k--) begin
      cand = IW'((int'(ptr_i) + k) % N);
      if (req_i[cand]) begin
        grant_o       = '0;
        grant_o[cand] = 1'b1;
        idx_o         = cand;
        any_o         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rom_arbiter.sv
// Round-robin read arbiter in front of the single-port program ROM, with lock
// bursts and a tag pipeline that routes each returned byte to its requester.
module rom_arbiter
  import rom_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int AW     = ROM_AW,
  parameter int DW     = ROM_DW,
  parameter int RD_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ-1:0]    req_lock,
  output logic [NREQ-1:0]    req_ready,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [DW-1:0]      rsp_data,
  output logic [AW-1:0]      rom_addr,
  input  logic [DW-1:0]      rom_q
);

  localparam int IW = $clog2(NREQ);

  arb_state_e    state_q;
  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;
  logic [IW-1:0] owner_q;

  logic [NREQ-1:0] pick_grant;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;

  logic            gnt_any;
  logic [IW-1:0]   gnt_idx;

  logic [RD_LAT-1:0] tag_vld_q;
  logic [IW-1:0]     tag_id_q [RD_LAT];

  rr_pick #(.N(NREQ)) u_pick (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  // While locked only the owner may win; reset masks every grant.
  always_comb begin
    req_ready = '0;
    gnt_any   = 1'b0;
    gnt_idx   = pick_idx;
    if (!rst) begin
      if (state_q == LOCKED) begin
        gnt_any            = req_valid[owner_q];
        gnt_idx            = owner_q;
        req_ready[owner_q] = req_valid[owner_q];
      end else begin
        gnt_any   = pick_any;
        req_ready = pick_grant;
      end
    end
  end

  assign rom_addr = gnt_any ? req_addr[gnt_idx*AW +: AW] : '0;
  assign ptr_d    = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB;
      ptr_q   <= '0;
      owner_q <= '0;
    end else if (gnt_any) begin
      ptr_q   <= ptr_d;
      owner_q <= gnt_idx;
      state_q <= req_lock[gnt_idx] ? LOCKED : ARB;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld_q <= '0;
    end else begin
      tag_vld_q[0] <= gnt_any;
      for (int s = 1; s < RD_LAT; s++) tag_vld_q[s] <= tag_vld_q[s-1];
    end
  end

  // NOTE: the id array carries no reset; its contents are meaningless unless the
  // matching valid bit is set, and the valid bits are reset.
  always_ff @(posedge clk) begin
    tag_id_q[0] <= gnt_idx;
    for (int s = 1; s < RD_LAT; s++) tag_id_q[s] <= tag_id_q[s-1];
  end

  always_comb begin
    rsp_valid = '0;
    rsp_data  = '0;
    if (tag_vld_q[RD_LAT-1]) begin
      rsp_valid[tag_id_q[RD_LAT-1]] = 1'b1;
      rsp_data                      = rom_q;
    end
  end

endmodule
